// File: rtl/pwm_gen_core.sv
`timescale 1ns/1ps
// PWM generator core: shadowed period/duty, registered pin output, wrap/load status pulses.
// Latency: enable seen in IDLE at edge E0 enters RUN at E0; pwm_out reflects cnt=0 after E1.
// Backpressure: none; load_req is a 1-clk pulse, remembered in pend until the next wrap.
//
// Ports:
//   clk, rst            clock and asynchronous active-high reset
//   enable, invert      run/stop control and output polarity (invert is not shadowed)
//   period, duty        PWM period (period+1 clocks) and high time, captured into shadows
//   load_req            pulse requesting a shadow reload at the next counter wrap
//   pwm_out             registered PWM output
//   cycle_done          1-clk pulse at every counter wrap
//   load_ack            1-clk pulse when shadows reload at a wrap
//   cnt                 current counter value for status readback
module pwm_gen_core #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             invert,
    input  logic [CNT_W-1:0] period,
    input  logic [CNT_W-1:0] duty,
    input  logic             load_req,
    output logic             pwm_out,
    output logic             cycle_done,
    output logic             load_ack,
    output logic [CNT_W-1:0] cnt
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state, state_nxt;
    logic [CNT_W-1:0] period_sh, period_sh_nxt;
    logic [CNT_W-1:0] duty_sh, duty_sh_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             pend, pend_nxt;
    logic             pwm_nxt;
    logic             cycle_done_nxt;
    logic             load_ack_nxt;
    logic             wrap;
    logic             take;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            period_sh  <= '0;
            duty_sh    <= '0;
            pend       <= 1'b0;
            pwm_out    <= 1'b0;
            cycle_done <= 1'b0;
            load_ack   <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            period_sh  <= period_sh_nxt;
            duty_sh    <= duty_sh_nxt;
            pend       <= pend_nxt;
            pwm_out    <= pwm_nxt;
            cycle_done <= cycle_done_nxt;
            load_ack   <= load_ack_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        period_sh_nxt  = period_sh;
        duty_sh_nxt    = duty_sh;
        pend_nxt       = pend;
        pwm_nxt        = invert;      // inactive level unless running
        cycle_done_nxt = 1'b0;
        load_ack_nxt   = 1'b0;
        wrap           = (cnt == period_sh);
        // A request arriving in the wrap cycle itself is honoured at that wrap.
        take           = wrap & (pend | load_req);

        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (enable) begin
                    period_sh_nxt = period;
                    duty_sh_nxt   = duty;
                    pend_nxt      = 1'b0;
                    state_nxt     = RUN;
                end
            end
            RUN: begin
                if (!enable) begin
                    // Stop immediately, even mid-period; shadows are refreshed on restart.
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    pend_nxt  = 1'b0;
                end else begin
                    cnt_nxt        = wrap ? '0 : cnt + ONE;
                    cycle_done_nxt = wrap;
                    // Compare uses the pre-edge count, so the pin lags cnt by one clock.
                    pwm_nxt        = (cnt < duty_sh) ^ invert;
                    pend_nxt       = pend | load_req;
                    if (take) begin
                        period_sh_nxt = period;
                        duty_sh_nxt   = duty;
                        pend_nxt      = 1'b0;
                        load_ack_nxt  = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_pwm_gen_core.sv
`timescale 1ns/1ps
module tb_pwm_gen_core;

    typedef struct packed {
        logic [7:0]  tid;
        logic        pwm;
        logic        cd;
        logic        ack;
        logic [31:0] cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        invert = 1'b0;
    logic [31:0] period = '0;
    logic [31:0] duty = '0;
    logic        load_req = 1'b0;
    logic        pwm_out;
    logic        cycle_done;
    logic        load_ack;
    logic [31:0] cnt;

    exp_t exp_q[$];
    int   n_total = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    pwm_gen_core #(.CNT_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .invert     (invert),
        .period     (period),
        .duty       (duty),
        .load_req   (load_req),
        .pwm_out    (pwm_out),
        .cycle_done (cycle_done),
        .load_ack   (load_ack),
        .cnt        (cnt)
    );

    task automatic chk(input string name, input int tid, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s test=%0d t=%0t got=%0d expected=%0d", name, tid, $time, got, want);
        end
    endtask

    function automatic exp_t mk(input int tid, input bit p, input bit c, input bit a, input int n);
        exp_t e;
        e.tid = 8'(tid);
        e.pwm = p;
        e.cd  = c;
        e.ack = a;
        e.cnt = 32'(n);
        return e;
    endfunction

    // Expected outputs k edges after the enabling edge, for a run with fixed period p and duty d.
    function automatic exp_t run_exp(input int k, input int p, input int d, input bit inv, input int tid);
        if (k == 0)
            return mk(tid, inv, 1'b0, 1'b0, 0);
        return mk(tid, (((k - 1) % (p + 1)) < d) ^ inv, (k % (p + 1)) == 0, 1'b0, k % (p + 1));
    endfunction

    // One clock edge; queue the outputs expected to be visible after it.
    task automatic cyc(input exp_t e);
        @(posedge clk);
        #1;
        exp_q.push_back(e);
    endtask

    // Stop, load new register values, then enable; the idle edge is checked too.
    task automatic restart(input int p, input int d, input bit inv, input int tid);
        period = 32'(p);
        duty   = 32'(d);
        invert = inv;
        enable = 1'b0;
        cyc(mk(tid, inv, 1'b0, 1'b0, 0));
        enable = 1'b1;
    endtask

    // Monitor: compares the oldest expectation whenever outputs are sampled.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk or posedge rst);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("pwm_out", int'(e.tid), {31'd0, pwm_out}, {31'd0, e.pwm});
                chk("cycle_done", int'(e.tid), {31'd0, cycle_done}, {31'd0, e.cd});
                chk("load_ack", int'(e.tid), {31'd0, load_ack}, {31'd0, e.ack});
                chk("cnt", int'(e.tid), cnt, e.cnt);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, queue=%0d", exp_q.size());
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t e;
        // Reset state, then idle with enable low.
        cyc(mk(0, 0, 0, 0, 0));
        cyc(mk(0, 0, 0, 0, 0));
        rst = 1'b0;
        cyc(mk(0, 0, 0, 0, 0));

        // T1: 3 high / 7 low, cycle_done with cnt back at 0.
        restart(9, 3, 0, 1);
        for (int k = 0; k < 26; k++) cyc(run_exp(k, 9, 3, 0, 1));

        // T2: duty boundaries, both polarities.
        restart(9, 0, 0, 2);
        for (int k = 0; k < 12; k++) cyc(run_exp(k, 9, 0, 0, 2));
        restart(9, 12, 0, 2);
        for (int k = 0; k < 12; k++) cyc(run_exp(k, 9, 12, 0, 2));
        restart(9, 0, 1, 2);
        for (int k = 0; k < 12; k++) cyc(run_exp(k, 9, 0, 1, 2));
        restart(9, 12, 1, 2);
        for (int k = 0; k < 12; k++) cyc(run_exp(k, 9, 12, 1, 2));

        // T3: duty write mid-period at cnt=5; applies after the wrap at k=20.
        restart(9, 3, 0, 3);
        for (int k = 0; k < 36; k++) begin
            e = run_exp(k, 9, (k >= 21) ? 7 : 3, 0, 3);
            if (k == 20) e.ack = 1'b1;
            cyc(e);
            if (k == 15) begin
                duty     = 32'd7;
                load_req = 1'b1;
            end
            if (k == 16) load_req = 1'b0;
        end

        // T4: load_req in the wrap cycle (cnt=9) applies at that same wrap.
        restart(9, 3, 0, 4);
        for (int k = 0; k < 26; k++) begin
            e = run_exp(k, 9, (k >= 11) ? 5 : 3, 0, 4);
            if (k == 10) e.ack = 1'b1;
            cyc(e);
            if (k == 9) begin
                duty     = 32'd5;
                load_req = 1'b1;
            end
            if (k == 10) load_req = 1'b0;
        end

        // T5: enable dropped at cnt=2 while high; restart latches fresh values; invert live.
        restart(9, 3, 0, 5);
        for (int k = 0; k < 3; k++) cyc(run_exp(k, 9, 3, 0, 5));
        enable = 1'b0;
        cyc(mk(5, 0, 0, 0, 0));
        restart(4, 2, 0, 5);
        for (int k = 0; k < 13; k++) begin
            cyc(run_exp(k, 4, 2, k >= 8, 5));
            if (k == 7) invert = 1'b1;
        end

        // T6: period=0 wraps every clock; async reset mid-run; recovery via IDLE.
        restart(0, 1, 0, 6);
        for (int k = 0; k < 8; k++) cyc(run_exp(k, 0, 1, 0, 6));
        period = 32'd2;
        duty   = 32'd1;
        @(negedge clk);
        #2;
        rst = 1'b1;
        exp_q.push_back(mk(6, 0, 0, 0, 0));
        cyc(mk(6, 0, 0, 0, 0));
        rst = 1'b0;
        for (int k = 0; k < 9; k++) cyc(run_exp(k, 2, 1, 0, 7));

        repeat (2) @(negedge clk);
        #3;
        chk("queue_drained", 8, 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
